seg_scan_mux: RTL and testbench
===============================

Name: seg_scan_mux

Overview:
- Downstream stage of the cube timer: takes the three active-low 7-segment patterns (seconds-ones, seconds-tens, minutes) and time-multiplexes them onto one shared 4-digit common-anode display.
- Runs on the fast system clock, not the 1 Hz timer clock.
- Inserts a dead-time blank between digits to suppress ghosting.
- Shows a pause indicator on the fourth digit.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- SCAN_HZ, 1000, digit-slot rate in Hz. DIV = CLK_HZ/SCAN_HZ (integer) cycles per slot.
- BLANK_CYCLES, 16, dead-time cycles at the start of each slot. Requires DIV >= BLANK_CYCLES+4; otherwise elaboration error.

Ports:
- clk_100MHz  in  1  system clock, all logic on rising edge
- I_reset  in  1  synchronous, active-high reset
- I_enable  in  1  1 = scanning, 0 = display dark
- I_pause  in  1  level from timer control; 1 = show 'P' on digit 3
- I_leds_s0  in  8  active-low pattern, seconds ones (bit7=a … bit1=g, bit0=dp)
- I_leds_s1  in  8  active-low pattern, seconds tens
- I_leds_m0  in  8  active-low pattern, minutes
- O_an  out  4  active-low anode select, bit n = digit n
- O_seg  out  8  active-low segment drive, same bit order as inputs

Behaviour:
- Reset (sync, active-high):
  - slot_cnt = 0, idx = 0.
  - O_an = 4'hF, O_seg = 8'hFF.
  - Reset mid-slot: outputs go dark on that edge; scanning restarts from digit 0.
- Registered state: slot_cnt counts 0..DIV-1; idx 2 bits, digit index 0..3. All outputs are registered; no combinational path from inputs to outputs.
- Each enabled edge:
  - If slot_cnt == DIV-1: slot_cnt <= 0, idx <= idx+1 (wraps 3 -> 0).
  - Else: slot_cnt <= slot_cnt+1.
- Two-phase state per slot:
  - BLANK while slot_cnt < BLANK_CYCLES.
  - ON while slot_cnt >= BLANK_CYCLES.
- Output rule:
  - On the edge where slot_cnt becomes 0: O_an = 4'hF, O_seg = 8'hFF.
  - On the edge where slot_cnt becomes BLANK_CYCLES: O_an = ~(4'b0001 << idx), and O_seg loads the digit pattern sampled on that same edge.
  - O_seg is then held constant to the end of the slot. Input changes mid-slot are not visible until the next visit to that digit, so there is no tearing.
- Digit map:
  - idx 0: I_leds_s0.
  - idx 1: I_leds_s1.
  - idx 2: I_leds_m0 with bit0 forced 0, so the dp lights as the min/sec separator.
  - idx 3: 8'h31 ('P') if I_pause = 1, else 8'hFF.
- Enable:
  - I_enable = 0 on an edge: O_an = 4'hF, O_seg = 8'hFF, slot_cnt = 0, idx = 0, all held there.
  - On the first edge with I_enable = 1: slot_cnt = 1. This is identical to the sequence after reset.
- Reset has priority over enable.
- At most one anode is low at any time. All anodes are high for BLANK_CYCLES cycles between consecutive digits.
- Full frame = 4*DIV cycles; refresh = SCAN_HZ/4 Hz.

Optional Feature:
- Macro: SEG_SCAN_DIM_EN.
- Defined:
  - Adds port I_bright (in, 2 bits), sampled on the edge where slot_cnt becomes 0.
  - ON_LEN = ((DIV-BLANK_CYCLES)*(bright+1))>>2.
  - On the edge where slot_cnt becomes BLANK_CYCLES+ON_LEN: if that value < DIV, O_an = 4'hF and O_seg = 8'hFF for the rest of the slot.
  - bright = 3 gives full on-time.
- Not defined: port absent; behaviour is identical to bright = 3.

Test Plan (sim params CLK_HZ=64, SCAN_HZ=4, so DIV=16; BLANK_CYCLES=2):
- Reset, then I_enable=1, s0=8'h03, s1=8'h9f, m0=8'h25, pause=0:
  - 2nd edge after release: O_an=4'b1110, O_seg=8'h03.
  - Then 8'h9f on 4'b1101, 8'h24 on 4'b1011, 8'hFF on 4'b0111, each 14 cycles ON after 2 blank cycles.
  - Frame repeats every 64 cycles.
- pause=1: digit 3 slot shows O_an=4'b0111, O_seg=8'h31. pause toggled mid-slot of digit 3: no change until the next frame.
- Change s0 from 8'h03 to 8'h9f mid digit-0 ON phase: O_seg stays 8'h03 until slot end; next digit-0 slot shows 8'h9f.
- Assert I_reset for 1 cycle at slot_cnt=7 of digit 2: next edge O_an=4'hF, O_seg=8'hFF; digit 0 re-lights 2 edges after release.
- I_enable=0 for 5 cycles mid-frame: outputs dark throughout; re-enable restarts at digit 0. Assertion: popcount(~O_an) <= 1 on every cycle.
- SEG_SCAN_DIM_EN with bright=1: ON_LEN=7; each digit is lit for slot_cnt 2..8 and dark for slot_cnt 9..15. With bright=3: lit for slot_cnt 2..15.

Source files
------------

// File: rtl/seg_scan_mux_if.sv
// ---------------------------------------------------------------------------
// seg_scan_mux_if
//   Bundle between the cube-timer digit sources and the scan multiplexer.
//
//   Signals
//     I_leds_s0  [7:0]  active-low pattern, seconds ones (bit7=a .. bit1=g, bit0=dp)
//     I_leds_s1  [7:0]  active-low pattern, seconds tens
//     I_leds_m0  [7:0]  active-low pattern, minutes
//     I_pause           1 = show 'P' on digit 3
//     O_an       [3:0]  active-low anode select, bit n = digit n
//     O_seg      [7:0]  active-low segment drive, same bit order as the inputs
//     dbg_phase  [1:0]  scan FSM state, for observation only
//
//   Modports
//     master : the side that supplies the patterns and watches the display
//     slave  : the scan multiplexer
// ---------------------------------------------------------------------------
interface seg_scan_mux_if;
    logic [7:0] I_leds_s0;
    logic [7:0] I_leds_s1;
    logic [7:0] I_leds_m0;
    logic       I_pause;
    logic [3:0] O_an;
    logic [7:0] O_seg;
    logic [1:0] dbg_phase;

    modport master (
        output I_leds_s0, I_leds_s1, I_leds_m0, I_pause,
        input  O_an, O_seg, dbg_phase
    );

    modport slave (
        input  I_leds_s0, I_leds_s1, I_leds_m0, I_pause,
        output O_an, O_seg, dbg_phase
    );
endinterface

// File: rtl/seg_scan_mux.sv
// ---------------------------------------------------------------------------
// seg_scan_mux
//   Time-multiplexes the three cube-timer digit patterns plus a pause
//   indicator onto one shared 4-digit common-anode 7-segment display.
//   Each digit owns a slot of DIV = CLK_HZ/SCAN_HZ cycles; the first
//   BLANK_CYCLES of every slot keep all anodes off to suppress ghosting.
//   All outputs are registered; the pattern is captured once per slot so a
//   digit never tears mid-slot.
//
//   Ports
//     clk_100MHz  in   system clock, all logic on the rising edge
//     I_reset     in   synchronous, active-high reset (priority over enable)
//     I_enable    in   1 = scanning, 0 = display dark and scan held at digit 0
//     I_bright    in   [1:0] brightness, only with SEG_SCAN_DIM_EN defined
//     bus         slave modport of seg_scan_mux_if (patterns in, an/seg out)
//
//   Build option
//     SEG_SCAN_DIM_EN : adds I_bright and shortens the lit part of each slot
//                       to ((DIV-BLANK_CYCLES)*(bright+1))>>2 cycles.
//                       Undefined: the lit part always runs to slot end.
//
//   Handshake: none. The digit patterns are levels; they are sampled only on
//   the edge where a digit lights and are ignored for the rest of the slot.
// ---------------------------------------------------------------------------
module seg_scan_mux #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int SCAN_HZ      = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                clk_100MHz,
    input  logic                I_reset,
    input  logic                I_enable,
`ifdef SEG_SCAN_DIM_EN
    input  logic [1:0]          I_bright,
`endif
    seg_scan_mux_if.slave       bus
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    // Scan FSM states
    localparam logic [1:0] PH_IDLE  = 2'd0;  // reset or disabled, display dark
    localparam logic [1:0] PH_BLANK = 2'd1;  // dead time at slot start
    localparam logic [1:0] PH_ON    = 2'd2;  // digit lit
`ifdef SEG_SCAN_DIM_EN
    localparam logic [1:0] PH_DIM   = 2'd3;  // on-time used up, dark to slot end
`endif

    generate
        if (DIV < BLANK_CYCLES + 4) begin : g_bad_cfg
            $error("seg_scan_mux: DIV must be at least BLANK_CYCLES+4");
        end
    endgenerate

    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;
    logic [1:0]       phase_q, phase_d;
    logic [7:0]       digit_pat;
`ifdef SEG_SCAN_DIM_EN
    logic [1:0]       bright_q, bright_d;
`endif

    always_comb begin
        slot_cnt_d = slot_cnt_q;
        idx_d      = idx_q;
        an_d       = an_q;
        seg_d      = seg_q;
        phase_d    = phase_q;
        digit_pat  = 8'hFF;

        if (!I_enable) begin
            slot_cnt_d = '0;
            idx_d      = '0;
            an_d       = 4'hF;
            seg_d      = 8'hFF;
            phase_d    = PH_IDLE;
        end else begin
            if (slot_cnt_q == SLOT_LAST) begin
                slot_cnt_d = '0;
                idx_d      = idx_q + 2'd1;
            end else begin
                slot_cnt_d = slot_cnt_q + 1'b1;
            end

            // Digit chosen by the index the slot will have after this edge,
            // so the lit digit always matches the slot it appears in.
            case (idx_d)
                2'd0:    digit_pat = bus.I_leds_s0;
                2'd1:    digit_pat = bus.I_leds_s1;
                2'd2:    digit_pat = {bus.I_leds_m0[7:1], 1'b0};  // dp = min/sec separator
                default: digit_pat = bus.I_pause ? 8'h31 : 8'hFF;
            endcase

            if (slot_cnt_d == '0) begin
                an_d    = 4'hF;
                seg_d   = 8'hFF;
                phase_d = PH_BLANK;
            end else if (phase_q == PH_IDLE) begin
                // First enabled edge after reset/disable: counter is at 1.
                phase_d = PH_BLANK;
            end

            if (slot_cnt_d == BLANK_END) begin
                an_d    = ~(4'b0001 << idx_d);
                seg_d   = digit_pat;
                phase_d = PH_ON;
            end
`ifdef SEG_SCAN_DIM_EN
            else begin
                int cut_pos;
                cut_pos = BLANK_CYCLES
                        + (((DIV - BLANK_CYCLES) * (int'(bright_q) + 1)) >> 2);
                // A cut point at or past DIV means full on-time: never reached.
                if (cut_pos < DIV && int'(slot_cnt_d) == cut_pos) begin
                    an_d    = 4'hF;
                    seg_d   = 8'hFF;
                    phase_d = PH_DIM;
                end
            end
`endif
        end
    end

`ifdef SEG_SCAN_DIM_EN
    // Brightness is captured whenever the counter lands on 0, so it stays
    // constant for the whole slot that follows.
    always_comb begin
        bright_d = bright_q;
        if (slot_cnt_d == '0) begin
            bright_d = I_bright;
        end
    end
`endif

    always_ff @(posedge clk_100MHz) begin
        if (I_reset) begin
            slot_cnt_q <= '0;
            idx_q      <= '0;
            an_q       <= 4'hF;
            seg_q      <= 8'hFF;
            phase_q    <= PH_IDLE;
`ifdef SEG_SCAN_DIM_EN
            bright_q   <= I_bright;
`endif
        end else begin
            slot_cnt_q <= slot_cnt_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            phase_q    <= phase_d;
`ifdef SEG_SCAN_DIM_EN
            bright_q   <= bright_d;
`endif
        end
    end

    assign bus.O_an      = an_q;
    assign bus.O_seg     = seg_q;
    assign bus.dbg_phase = phase_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_mux
//   Directed bench for seg_scan_mux with CLK_HZ=64, SCAN_HZ=4 (DIV=16) and
//   BLANK_CYCLES=2. Edge numbers in the tags count enabled edges since the
//   last reset/enable release; the digit for edge e is (e/16)%4 and it is lit
//   while e%16 >= 2.
// ---------------------------------------------------------------------------
module tb_seg_scan_mux;

    localparam int CLK_HZ       = 64;
    localparam int SCAN_HZ      = 4;
    localparam int BLANK_CYCLES = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic en;
`ifdef SEG_SCAN_DIM_EN
    logic [1:0] bright;
`endif

    always #5 clk = ~clk;

    seg_scan_mux_if bus ();

    seg_scan_mux #(
        .CLK_HZ       (CLK_HZ),
        .SCAN_HZ      (SCAN_HZ),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_dut (
        .clk_100MHz (clk),
        .I_reset    (rst),
        .I_enable   (en),
`ifdef SEG_SCAN_DIM_EN
        .I_bright   (bright),
`endif
        .bus        (bus)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [11:0] exp_q[$];

    task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] an, input logic [7:0] seg);
        logic [11:0] e;
        exp_q.push_back({an, seg});
        e = exp_q.pop_front();
        check_val(tag, {4'h0, bus.O_an, bus.O_seg}, {4'h0, e});
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // At most one anode low on every cycle.
    always @(negedge clk) begin
        check_val("an_onehot", 16'($countones(~bus.O_an) <= 1), 16'd1);
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        en  = 1'b1;
        bus.I_leds_s0 = 8'h03;
        bus.I_leds_s1 = 8'h9f;
        bus.I_leds_m0 = 8'h25;
        bus.I_pause   = 1'b0;
`ifdef SEG_SCAN_DIM_EN
        bright = 2'd3;
`endif
        step(2);
        expect_out("reset_dark", 4'hF, 8'hFF);
        check_val("reset_phase", {14'd0, bus.dbg_phase}, 16'd0);

        rst = 1'b0;
        step(1);  expect_out("e1_blank", 4'hF, 8'hFF);
        check_val("e1_phase", {14'd0, bus.dbg_phase}, 16'd1);
        step(1);  expect_out("e2_d0_on", 4'b1110, 8'h03);
        check_val("e2_phase", {14'd0, bus.dbg_phase}, 16'd2);
        step(13); expect_out("e15_d0_hold", 4'b1110, 8'h03);
        step(1);  expect_out("e16_blank", 4'hF, 8'hFF);
        step(1);  expect_out("e17_blank", 4'hF, 8'hFF);
        step(1);  expect_out("e18_d1_on", 4'b1101, 8'h9f);
        step(16); expect_out("e34_d2_on", 4'b1011, 8'h24);
        step(16); expect_out("e50_d3_nopause", 4'b0111, 8'hFF);
        step(13); expect_out("e63_d3_hold", 4'b0111, 8'hFF);
        step(1);  expect_out("e64_frame_blank", 4'hF, 8'hFF);
        step(2);  expect_out("e66_frame_repeat", 4'b1110, 8'h03);

        // Pause indicator, and a pause drop mid-slot must not tear digit 3.
        bus.I_pause = 1'b1;
        step(48); expect_out("e114_pause_p", 4'b0111, 8'h31);
        step(6);  bus.I_pause = 1'b0;
        step(7);  expect_out("e127_pause_held", 4'b0111, 8'h31);
        step(51); expect_out("e178_pause_gone", 4'b0111, 8'hFF);

        // s0 change during digit-0 ON phase shows only on the next visit.
        step(18); expect_out("e196_d0_old", 4'b1110, 8'h03);
        bus.I_leds_s0 = 8'h9f;
        step(11); expect_out("e207_d0_still_old", 4'b1110, 8'h03);
        step(51); expect_out("e258_d0_new", 4'b1110, 8'h9f);

        // One-cycle reset at slot_cnt=7 of digit 2.
        step(37); expect_out("e295_d2_lit", 4'b1011, 8'h24);
        rst = 1'b1;
        step(1);  expect_out("midreset_dark", 4'hF, 8'hFF);
        check_val("midreset_phase", {14'd0, bus.dbg_phase}, 16'd0);
        rst = 1'b0;
        step(1);  expect_out("rst_e1_blank", 4'hF, 8'hFF);
        step(1);  expect_out("rst_e2_d0", 4'b1110, 8'h9f);

        // Disable for 5 cycles mid-frame.
        step(18); expect_out("e20_d1_lit", 4'b1101, 8'h9f);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            expect_out("disabled_dark", 4'hF, 8'hFF);
        end
        en = 1'b1;
        step(1);  expect_out("reen_e1_blank", 4'hF, 8'hFF);
        step(1);  expect_out("reen_e2_d0", 4'b1110, 8'h9f);

`ifdef SEG_SCAN_DIM_EN
        // bright=1: on-time 7 cycles, lit for slot_cnt 2..8.
        bright = 2'd1;
        step(14); expect_out("dim_e16_blank", 4'hF, 8'hFF);
        step(2);  expect_out("dim_e18_on", 4'b1101, 8'h9f);
        step(6);  expect_out("dim_e24_last_on", 4'b1101, 8'h9f);
        step(1);  expect_out("dim_e25_cut", 4'hF, 8'hFF);
        check_val("dim_e25_phase", {14'd0, bus.dbg_phase}, 16'd3);
        step(6);  expect_out("dim_e31_dark", 4'hF, 8'hFF);
        bright = 2'd3;
        step(10); expect_out("dim_e41_full", 4'b1011, 8'h24);
        step(22); expect_out("dim_e63_full", 4'b0111, 8'hFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
